timer_array: RTL
================

TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (legal 1..4).
REQ-002 SHALL have parameter CNT_W, default 32, counter/preset width in bits (legal 8..32).
REQ-003 SHALL have port Clock  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port Addr  in  4  word address; [3:2] = channel, [1:0] = register (0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS).
REQ-006 SHALL have port WE  in  1  full-word write enable, sampled on Clock rising edge.
REQ-007 SHALL have port WD  in  32  write data.
REQ-008 SHALL have port RD  out  32  combinational read data for Addr.
REQ-009 SHALL have port IRQ  out  NUM_CH  per-channel interrupt request, bit i = channel i.
REQ-010 SHALL have port IRQ_Any  out  1  OR of all IRQ bits.

Function
REQ-011 CTRL SHALL hold Enable [0], Mode [2:1] (00 one-shot, 01 auto-reload, 1x treated as one-shot), IM interrupt mask [3]; other bits read 0 unless REQ-030 applies.
REQ-012 PRESET SHALL be read/write, CNT_W bits; COUNT SHALL be read-only; bits above CNT_W read 0, written bits truncated.
REQ-013 STATUS[0] SHALL be the pending flag; writing 1 to bit 0 clears it, writing 0 no effect.
REQ-014 Each channel SHALL run FSM IDLE, LOAD, CNT, INT; reset state IDLE.
REQ-015 IDLE -> LOAD on edge where Enable=1.
REQ-016 LOAD: COUNT <= PRESET, prescale counter <= 0; -> CNT next edge.
REQ-017 CNT: on each tick, if COUNT <= 1 then COUNT <= 0 and -> INT, else COUNT <= COUNT-1; no tick = hold.
REQ-018 Entry into INT SHALL set pending; if set and clear hit the same edge, set wins.
REQ-019 INT: mode 01 -> LOAD; otherwise clear Enable and -> IDLE; one cycle in INT.
REQ-020 A write of CTRL with Enable=0 SHALL force IDLE next edge from any state, suppressing a same-edge INT entry; COUNT holds; pending unaffected.
REQ-021 A CTRL write SHALL take priority over the automatic Enable clear of REQ-019.
REQ-022 PRESET writes during CNT SHALL take effect only at the next LOAD.
REQ-023 IRQ[i] SHALL equal pending[i] AND IM[i], registered-state-derived (no combinational path from WE/WD).
REQ-024 PRESET=0 SHALL behave as PRESET=1.
REQ-025 Latency: with PRESET=N>=1 and prescale p, IRQ SHALL rise on rising edge number N*(p+1)+2, counting the Enable-write edge as 1; auto-reload period N*(p+1)+2 cycles.
REQ-026 Addr channel >= NUM_CH: reads return 0, writes ignored.
REQ-027 Channels SHALL be fully independent; writes touch only the addressed channel/register.

Reset
REQ-028 While Reset=0: all CTRL, PRESET, COUNT, pending, prescale counters 0, FSMs IDLE, IRQ and IRQ_Any 0.
REQ-029 Reset assertion mid-count SHALL abort immediately (asynchronously); first post-release edge sees IDLE.

Configuration
REQ-030 With TIMER_ARRAY_PRESCALE_EN defined, CTRL[15:8] SHALL be an 8-bit prescale value p per channel; a tick occurs when the prescale counter equals p (then counter <= 0), i.e. every p+1 CNT cycles.
REQ-031 Without TIMER_ARRAY_PRESCALE_EN, CTRL[15:8] SHALL read 0, ignore writes, and every CNT cycle SHALL be a tick (p=0).

Verification
REQ-032 Ch0 PRESET=3, CTRL=0x9 (Enable, one-shot, IM) -> IRQ[0]/IRQ_Any rise on edge 5, COUNT=0, CTRL reads 0x8, IDLE.
REQ-033 Ch1 PRESET=2, CTRL=0xB (auto-reload) -> IRQ[1] rises edge 4; STATUS write 1 on the edge of second INT entry -> pending stays 1; period 4 cycles observed on COUNT.
REQ-034 Ch0 counting PRESET=10, write CTRL=0 at COUNT=5 -> IDLE next edge, COUNT holds 5, no IRQ; Reset=0 mid-count -> all outputs 0 immediately.
REQ-035 IM=0 completion -> STATUS=1, IRQ=0; then write CTRL IM=1 -> IRQ=1 next edge; STATUS write 1 -> IRQ=0 next edge.
REQ-036 With TIMER_ARRAY_PRESCALE_EN, PRESET=2, p=3 -> IRQ on edge 10; without macro, CTRL write 0xFF09 reads back 0x0009, IRQ on edge 4; NUM_CH=2 access to channel 3 reads 0.

Source files
------------

// File: rtl/timer_array.sv
`default_nettype none
// ============================================================================
// Module   : timer_array
// Purpose  : NUM_CH independent down-counting timers with a register-mapped
//            control interface and per-channel masked interrupts.
//            Optional 8-bit per-channel prescaler: TIMER_ARRAY_PRESCALE_EN.
// Revision : 1.0  initial release
// ============================================================================
module timer_array #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [3:0]        Addr,
    input  logic              WE,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    output logic [NUM_CH-1:0] IRQ,
    output logic              IRQ_Any
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    logic [NUM_CH-1:0][31:0] w_rd;
    logic                    w_unused_wd;

    // Only selected WD bits are architected; fold the rest away.
    assign w_unused_wd = ^WD;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           r_state;
        state_t           w_next;
        logic             r_en;
        logic [1:0]       r_mode;
        logic             r_im;
        logic [CNT_W-1:0] r_preset;
        logic [CNT_W-1:0] r_count;
        logic             r_pend;
        logic             w_sel;
        logic             w_wr_ctrl;
        logic             w_wr_pre;
        logic             w_wr_stat;
        logic             w_force_idle;
        logic             w_tick;
        logic             w_expire;
        logic             w_enter_int;
        logic [7:0]       w_psc;
        logic [31:0]      w_rd_ch;

        assign w_sel        = WE && (Addr[3:2] == 2'(i));
        assign w_wr_ctrl    = w_sel && (Addr[1:0] == 2'd0);
        assign w_wr_pre     = w_sel && (Addr[1:0] == 2'd1);
        assign w_wr_stat    = w_sel && (Addr[1:0] == 2'd3);
        assign w_force_idle = w_wr_ctrl && !WD[0];

`ifdef TIMER_ARRAY_PRESCALE_EN
        logic [7:0] r_psc;
        logic [7:0] r_pcnt;

        assign w_psc  = r_psc;
        assign w_tick = (r_pcnt == r_psc);

        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                r_psc  <= 8'd0;
                r_pcnt <= 8'd0;
            end else begin
                if (w_wr_ctrl) begin
                    r_psc <= WD[15:8];
                end
                if (!w_force_idle) begin
                    if (r_state == S_LOAD) begin
                        r_pcnt <= 8'd0;
                    end else if (r_state == S_CNT) begin
                        r_pcnt <= w_tick ? 8'd0 : r_pcnt + 8'd1;
                    end
                end
            end
        end
`else
        assign w_psc  = 8'd0;
        assign w_tick = 1'b1;
`endif

        // PRESET of 0 expires on the first tick, same as PRESET of 1.
        assign w_expire = w_tick && (r_count <= CNT_W'(1));

        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                r_state <= S_IDLE;
            end else begin
                r_state <= w_next;
            end
        end

        always_comb begin
            w_next = r_state;
            case (r_state)
                S_IDLE:  if (w_wr_ctrl ? WD[0] : r_en) w_next = S_LOAD;
                S_LOAD:  w_next = S_CNT;
                S_CNT:   if (w_expire) w_next = S_INT;
                S_INT:   w_next = (r_mode == 2'b01) ? S_LOAD : S_IDLE;
                default: w_next = S_IDLE;
            endcase
            if (w_force_idle) begin
                w_next = S_IDLE;
            end
        end

        assign w_enter_int = (r_state == S_CNT) && (w_next == S_INT);

        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                r_en     <= 1'b0;
                r_mode   <= 2'b00;
                r_im     <= 1'b0;
                r_preset <= '0;
                r_count  <= '0;
                r_pend   <= 1'b0;
            end else begin
                // A software CTRL write beats the one-shot auto-disable.
                if (w_wr_ctrl) begin
                    r_en   <= WD[0];
                    r_mode <= WD[2:1];
                    r_im   <= WD[3];
                end else if ((r_state == S_INT) && (r_mode != 2'b01)) begin
                    r_en <= 1'b0;
                end
                if (w_wr_pre) begin
                    r_preset <= WD[CNT_W-1:0];
                end
                if (!w_force_idle) begin
                    if (r_state == S_LOAD) begin
                        r_count <= r_preset;
                    end else if ((r_state == S_CNT) && w_tick) begin
                        r_count <= w_expire ? '0 : r_count - CNT_W'(1);
                    end
                end
                if (w_enter_int) begin
                    r_pend <= 1'b1;
                end else if (w_wr_stat && WD[0]) begin
                    r_pend <= 1'b0;
                end
            end
        end

        always_comb begin
            w_rd_ch = '0;
            case (Addr[1:0])
                2'd0:    w_rd_ch[15:0]      = {w_psc, 4'b0000, r_im, r_mode, r_en};
                2'd1:    w_rd_ch[CNT_W-1:0] = r_preset;
                2'd2:    w_rd_ch[CNT_W-1:0] = r_count;
                default: w_rd_ch[0]         = r_pend;
            endcase
        end

        assign w_rd[i] = w_rd_ch;
        assign IRQ[i]  = r_pend & r_im;
    end

    // Channels beyond NUM_CH match nothing and read as zero.
    always_comb begin
        RD = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (Addr[3:2] == 2'(k)) begin
                RD = w_rd[k];
            end
        end
    end

    assign IRQ_Any = |IRQ;

endmodule
`default_nettype wire
